// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive byte FIFO with valid/ready read side, sticky overflow and line-idle pulse
// Optional `UART_RX_BUFFER_LEVEL_EN adds the level output (current FIFO occupancy).
module uart_rx_buffer #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 16,
    parameter int IDLE_CYCLES = 17360
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DATA_BITS-1:0]   rx_data,
    input  logic                   rx_valid,
    output logic [DATA_BITS-1:0]   m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   overflow,
    input  logic                   overflow_clr,
`ifdef UART_RX_BUFFER_LEVEL_EN
    output logic [$clog2(DEPTH):0] level,
`endif
    output logic                   idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [IW-1:0] TERM_CNT = IW'(IDLE_CYCLES - 1);

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } idle_state_e;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    idle_state_e          state_q, state_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 idle_q, idle_d;

    logic push;
    logic pop;
    logic drop;

    // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
    assign pop  = (count_q != '0) && m_ready;
    assign push = rx_valid && ((count_q != FULL_CNT) || pop);
    assign drop = rx_valid && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        idle_d     = 1'b0;
        if (rx_valid) begin
            state_d    = ARMED;
            idle_cnt_d = '0;
        end else if (state_q == ARMED) begin
            if (idle_cnt_q == TERM_CNT) begin
                idle_d     = 1'b1;
                state_d    = DISARMED;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= DISARMED;
            idle_cnt_q <= '0;
            idle_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
        end
    end

    // Gate the head word so stale memory never shows while empty or in reset.
    assign m_valid  = (count_q != '0);
    assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow = overflow_q;
    assign idle     = idle_q;
`ifdef UART_RX_BUFFER_LEVEL_EN
    assign level    = count_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - scoreboard bench for uart_rx_buffer with randomized traffic
module tb_uart_rx_buffer;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;
    localparam int IDLE      = 24;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 overflow;
    logic                 overflow_clr;
    logic                 idle;
`ifdef UART_RX_BUFFER_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    uart_rx_buffer #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH      (DEPTH),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .overflow    (overflow),
        .overflow_clr(overflow_clr),
`ifdef UART_RX_BUFFER_LEVEL_EN
        .level       (level),
`endif
        .idle        (idle)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         occ = 0;
    logic       exp_ovf = 1'b0;
    logic       exp_idle = 1'b0;
    bit         armed = 1'b0;
    int         tcyc = 0;
    int         last_rx = 0;
    bit         mon_en = 1'b0;
    int         npulse = 0;
    int         nread = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain occupancy count plus byte queue, sticky flag, and
    // an idle timer expressed as "cycles since last strobe".
    task automatic cyc(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        bit pop;
        bit push;
        rx_valid     = v;
        rx_data      = d;
        m_ready      = rdy;
        overflow_clr = clr;
        @(posedge clk);
        tcyc++;
        pop  = (occ != 0) && rdy;
        push = v && ((occ < DEPTH) || pop);
        if (push) exp_q.push_back(d);
        occ = occ + int'(push) - int'(pop);
        if (v && !push) exp_ovf = 1'b1;
        else if (clr)   exp_ovf = 1'b0;
        exp_idle = 1'b0;
        if (v) begin
            armed   = 1'b1;
            last_rx = tcyc;
        end else if (armed && (tcyc - last_rx == IDLE)) begin
            exp_idle = 1'b1;
            armed    = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("m_data", 32'(m_data), 32'(exp_q[0]));
                if (m_ready) begin
                    last_rd = m_data;
                    void'(exp_q.pop_front());
                    nread++;
                end
            end
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("idle", 32'(idle), 32'(exp_idle));
            if (idle === 1'b1) npulse++;
`ifdef UART_RX_BUFFER_LEVEL_EN
            chk("level", 32'(level), 32'(occ));
`endif
        end
    end

    initial begin
        int base;
        int rdy_pct;
        int n;
        rstn = 1'b0; rx_valid = 1'b0; rx_data = '0; m_ready = 1'b0; overflow_clr = 1'b0;
        #2;
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_idle", 32'(idle), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Three bytes held, then read out in order
        cyc(1, 8'h49, 0, 0);
        cyc(1, 8'h41, 0, 0);
        cyc(1, 8'h4E, 0, 0);
        chk("hold_m_valid", 32'(m_valid), 32'd1);
        chk("hold_m_data", 32'(m_data), 32'h49);
        base = nread;
        repeat (4) cyc(0, 8'h00, 1, 0);
        chk("read3_count", 32'(nread - base), 32'd3);
        chk("read3_last", 32'(last_rd), 32'h4E);
        chk("read3_empty", 32'(m_valid), 32'd0);

        // 17 strobes into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) cyc(1, 8'(i), 0, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        base = nread;
        repeat (17) cyc(0, 8'h00, 1, 0);
        chk("ovf_reads", 32'(nread - base), 32'd16);
        chk("ovf_last", 32'(last_rd), 32'h0F);
        cyc(0, 8'h00, 0, 1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO, simultaneous pop and push of 0xAA
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h30 + i), 0, 0);
        base = nread;
        cyc(1, 8'hAA, 1, 0);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        repeat (DEPTH + 1) cyc(0, 8'h00, 1, 0);
        chk("full_pp_reads", 32'(nread - base), 32'd17);
        chk("full_pp_last", 32'(last_rd), 32'hAA);

        // Single byte then long silence: exactly one pulse
        repeat (2 * IDLE) cyc(0, 8'h00, 1, 0);
        npulse = 0;
        cyc(1, 8'h55, 1, 0);
        repeat (4 * IDLE) cyc(0, 8'h00, 1, 0);
        chk("idle_once", 32'(npulse), 32'd1);

        // Byte lands on the terminal cycle: restart, no pulse yet
        npulse = 0;
        cyc(1, 8'h11, 1, 0);
        repeat (IDLE - 1) cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h22, 1, 0);
        repeat (2) cyc(0, 8'h00, 1, 0);
        chk("idle_term_none", 32'(npulse), 32'd0);
        repeat (IDLE + 5) cyc(0, 8'h00, 1, 0);
        chk("idle_term_one", 32'(npulse), 32'd1);

        // Randomized traffic with occasional near-terminal silences
        rdy_pct = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) rdy_pct = (i / 250 % 3 == 0) ? 90 : ((i / 250 % 3 == 1) ? 15 : 50);
            if ($urandom_range(0, 99) < 2) begin
                n = $urandom_range(IDLE - 2, IDLE + 2);
                repeat (n) cyc(0, 8'h00, 1'($urandom_range(0, 1)), 0);
            end else begin
                cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 19) == 0);
            end
        end
        repeat (DEPTH + 2) cyc(0, 8'h00, 1, 0);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        cyc(0, 8'h00, 0, 1);

        // Asynchronous reset with 5 bytes held and overflow set
        for (int i = 0; i <= DEPTH; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
        repeat (DEPTH - 5) cyc(0, 8'h00, 1, 0);
        rx_valid = 1'b0; m_ready = 1'b0; overflow_clr = 1'b0;
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        #2;
        mon_en = 1'b0;
        rstn   = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_idle", 32'(idle), 32'd0);
`ifdef UART_RX_BUFFER_LEVEL_EN
        chk("arst_level", 32'(level), 32'd0);
`endif
        exp_q.delete();
        occ = 0; exp_ovf = 1'b0; exp_idle = 1'b0; armed = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        mon_en = 1'b1;
        repeat (3 * IDLE) cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h5A, 0, 0);
        chk("post_rst_data", 32'(m_data), 32'h5A);
        repeat (IDLE + 4) cyc(0, 8'h00, 1, 0);
        chk("post_rst_empty", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
